// File: rtl/fork_sched_pkg.sv
// rtl/fork_sched_pkg.sv - shared state encoding and sizing helpers for the packet fork scheduler
package fork_sched_pkg;

  localparam int CNT_W_DEF = 16;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SELECT = 2'd1,
    ST_STREAM = 2'd2,
    ST_DONE   = 2'd3
  } sched_state_e;

  function automatic int ch_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rr_mask_arbiter.sv
// rtl/rr_mask_arbiter.sv - next enabled channel strictly after the last grant, searching upward with wrap
module rr_mask_arbiter #(
  parameter int N    = 4,
  parameter int CH_W = 2
) (
  input  logic [N-1:0]    mask_i,
  input  logic [CH_W-1:0] last_i,
  input  logic            grant_en_i,
  output logic [CH_W-1:0] grant_o,
  output logic            grant_valid_o
);

  logic            found;
  logic [CH_W-1:0] idx_c;

  // k runs to N so a single-bit mask wraps back onto the last grant itself
  always_comb begin
    grant_o = '0;
    found   = 1'b0;
    idx_c   = '0;
    for (int k = 1; k <= N; k++) begin
      idx_c = CH_W'((int'(last_i) + k) % N);
      if (!found && mask_i[idx_c]) begin
        grant_o = idx_c;
        found   = 1'b1;
      end
    end
    grant_valid_o = found & grant_en_i;
  end

endmodule

// File: rtl/fork_dispatch_sched.sv
// rtl/fork_dispatch_sched.sv - round-robin whole-packet dispatch of one stream to Channel streams; FORK_SCHED_STATS_EN adds ch_pkt_cnt
module fork_dispatch_sched
  import fork_sched_pkg::*;
#(
  parameter int  Channel    = 4,
  parameter int  DATA_WIDTH = 64,
  parameter int  CNT_W      = CNT_W_DEF,
  localparam int CH_W       = ch_w(Channel)
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          start,
  input  logic [CNT_W-1:0]              cfg_pkt_num,
  input  logic [Channel-1:0]            cfg_ch_en,
  output logic                          busy,
  output logic                          o_tx_done,
  output logic                          s_axis_tready,
  input  logic [DATA_WIDTH-1:0]         s_axis_tdata,
  input  logic                          s_axis_tlast,
  input  logic                          s_axis_tvalid,
  input  logic [Channel-1:0]            m_axis_tready,
  output logic [Channel*DATA_WIDTH-1:0] m_axis_tdata,
  output logic [Channel-1:0]            m_axis_tlast,
  output logic [Channel-1:0]            m_axis_tvalid,
  output logic [CH_W-1:0]               cur_ch
`ifdef FORK_SCHED_STATS_EN
 ,output logic [Channel*CNT_W-1:0]      ch_pkt_cnt
`endif
);

  sched_state_e       state_q, state_d;
  logic [CH_W-1:0]    cur_q, cur_d, last_q, last_d;
  logic [CH_W-1:0]    arb_grant;
  logic               arb_valid;
  logic [CNT_W-1:0]   total_q, total_d, cnt_q, cnt_d;
  logic [Channel-1:0] mask_q, mask_d;
  logic               hs_last;

  rr_mask_arbiter #(.N(Channel), .CH_W(CH_W)) u_arb (
    .mask_i        (mask_q),
    .last_i        (last_q),
    .grant_en_i    (state_q == ST_SELECT),
    .grant_o       (arb_grant),
    .grant_valid_o (arb_valid)
  );

  assign hs_last = (state_q == ST_STREAM) && s_axis_tvalid && m_axis_tready[cur_q] && s_axis_tlast;

  assign m_axis_tdata = {Channel{s_axis_tdata}};
  assign m_axis_tlast = {Channel{s_axis_tlast}};
  assign cur_ch       = cur_q;

  always_comb begin
    state_d       = state_q;
    cur_d         = cur_q;
    last_d        = last_q;
    total_d       = total_q;
    cnt_d         = cnt_q;
    mask_d        = mask_q;
    busy          = 1'b0;
    o_tx_done     = 1'b0;
    s_axis_tready = 1'b0;
    m_axis_tvalid = '0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          // an empty count or empty mask finishes immediately without sending
          if (cfg_pkt_num == '0 || cfg_ch_en == '0) begin
            state_d = ST_DONE;
          end else begin
            total_d = cfg_pkt_num;
            mask_d  = cfg_ch_en;
            cnt_d   = '0;
            state_d = ST_SELECT;
          end
        end
      end
      ST_SELECT: begin
        busy = 1'b1;
        if (arb_valid) begin
          cur_d   = arb_grant;
          last_d  = arb_grant;
          state_d = ST_STREAM;
        end else begin
          state_d = ST_DONE;
        end
      end
      ST_STREAM: begin
        busy                 = 1'b1;
        s_axis_tready        = m_axis_tready[cur_q];
        m_axis_tvalid[cur_q] = s_axis_tvalid;
        if (hs_last) begin
          cnt_d   = cnt_q + 1'b1;
          state_d = (cnt_d == total_q) ? ST_DONE : ST_SELECT;
        end
      end
      ST_DONE: begin
        o_tx_done = 1'b1;
        state_d   = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cur_q   <= '0;
      last_q  <= CH_W'(Channel - 1);
      total_q <= '0;
      cnt_q   <= '0;
      mask_q  <= '0;
    end else begin
      state_q <= state_d;
      cur_q   <= cur_d;
      last_q  <= last_d;
      total_q <= total_d;
      cnt_q   <= cnt_d;
      mask_q  <= mask_d;
    end
  end

`ifdef FORK_SCHED_STATS_EN
  logic [Channel-1:0][CNT_W-1:0] stats_q;

  always_ff @(posedge clk) begin
    if (rst || (state_q == ST_IDLE && start)) begin
      stats_q <= '0;
    end else if (hs_last && stats_q[cur_q] != '1) begin
      stats_q[cur_q] <= stats_q[cur_q] + 1'b1;
    end
  end

  assign ch_pkt_cnt = stats_q;
`endif

endmodule
